// File: rtl/secuenciador_instr_pkg.sv
// Shared definitions for the instruction sequencer and its consumers.
// Holds the opcode constants also used by the control decoder, the state
// encoding of the sequencer FSM, and the field layout of an instruction word.
//
// Instruction word layout, from the MSB down:
//   [IW-1 : IW-2]  opcode
//   next RW bits    dir_a  (slot 0)
//   next RW bits    dir_b  (slot 1)
//   next RW bits    dir_w  (slot 2)
//   remaining low bits are ignored
package secuenciador_instr_pkg;

    localparam int OP_W = 2;

    localparam logic [OP_W-1:0] OP_SUMA  = 2'b00;
    localparam logic [OP_W-1:0] OP_RESTA = 2'b01;
    localparam logic [OP_W-1:0] OP_TERN  = 2'b10;
    localparam logic [OP_W-1:0] OP_SW    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_STALL = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Register-address slots packed right below the opcode.
    localparam int SLOT_A = 0;
    localparam int SLOT_B = 1;
    localparam int SLOT_W = 2;

    // LSB position of a register-address slot inside an iw-bit word whose
    // register fields are rw bits wide.
    function automatic int field_lsb(input int iw, input int rw, input int slot);
        return iw - OP_W - (slot + 1) * rw;
    endfunction

endpackage

// File: rtl/secuenciador_instr_if.sv
// Issue interface between the instruction sequencer (master) and the
// decode/datapath stage (slave).
//   opcode       master->slave  issued opcode
//   dir_a/dir_b  master->slave  source register addresses
//   dir_w        master->slave  destination register address
//   issue_valid  master->slave  fields above are valid
//   issue_ready  slave->master  consumer accepts the instruction
interface secuenciador_instr_if
    import secuenciador_instr_pkg::*;
#(
    parameter int RW = 4
) ();

    logic [OP_W-1:0] opcode;
    logic [RW-1:0]   dir_a;
    logic [RW-1:0]   dir_b;
    logic [RW-1:0]   dir_w;
    logic            issue_valid;
    logic            issue_ready;

    modport master (
        output opcode,
        output dir_a,
        output dir_b,
        output dir_w,
        output issue_valid,
        input  issue_ready
    );

    modport slave (
        input  opcode,
        input  dir_a,
        input  dir_b,
        input  dir_w,
        input  issue_valid,
        output issue_ready
    );

endinterface

// File: rtl/secuenciador_instr.sv
// Instruction fetch/issue sequencer.
// Walks a program stored in a synchronous-read ROM, splits every word into
// opcode and register addresses, and hands each instruction to the decode
// stage through a valid/ready handshake. After every accepted store a fixed
// number of idle cycles is inserted so the data-memory write can finish.
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   start        one-cycle pulse, begins execution at address 0 when idle
//   prog_len     number of instructions, sampled with start
//   rom_en       ROM read enable
//   rom_addr     ROM read address
//   rom_data     ROM read data, valid the cycle after rom_en
//   busy         high from start acceptance until the done pulse
//   done         one-cycle pulse when the program completes
//   iss          issue interface (master side)
module secuenciador_instr
    import secuenciador_instr_pkg::*;
#(
    parameter int AW       = 5,
    parameter int IW       = 16,
    parameter int RW       = 4,
    parameter int SW_STALL = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW:0]   prog_len,
    output logic          rom_en,
    output logic [AW-1:0] rom_addr,
    input  logic [IW-1:0] rom_data,
    output logic          busy,
    output logic          done,
    secuenciador_instr_if.master iss
);

    localparam int A_LSB = field_lsb(IW, RW, SLOT_A);
    localparam int B_LSB = field_lsb(IW, RW, SLOT_B);
    localparam int W_LSB = field_lsb(IW, RW, SLOT_W);

    // The counter must hold SW_STALL; keep at least one bit so a zero-stall
    // build still elaborates.
    localparam int            CW         = (SW_STALL > 0) ? $clog2(SW_STALL + 1) : 1;
    localparam logic [CW-1:0] STALL_INIT = CW'(SW_STALL);

    state_t          state_q, state_d;
    logic [AW:0]     pc_q, pc_d;
    logic [AW:0]     len_q, len_d;
    logic [AW:0]     pc_inc;
    logic [OP_W-1:0] op_q, op_d;
    logic [RW-1:0]   a_q, a_d;
    logic [RW-1:0]   b_q, b_d;
    logic [RW-1:0]   w_q, w_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            zero_done_q, zero_done_d;

    // pc and prog_len are compared at AW+1 bits so a full 2^AW program
    // terminates instead of wrapping.
    assign pc_inc = pc_q + 1'b1;

    // State register plus every piece of sequencer state. Reset mid-program
    // drops straight back to idle, so no done pulse can follow it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            len_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            w_q         <= '0;
            cnt_q       <= '0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            len_q       <= len_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            w_q         <= w_d;
            cnt_q       <= cnt_d;
            zero_done_q <= zero_done_d;
        end
    end

    // Next-state logic. Everything holds by default; the issue fields are
    // only rewritten while waiting on the ROM, so they keep the last issued
    // instruction for the rest of the time.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        len_d       = len_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        w_d         = w_q;
        cnt_d       = cnt_q;
        zero_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // An empty program never becomes busy; it only echoes a
                // done pulse on the following cycle.
                if (start) begin
                    if (prog_len != '0) begin
                        len_d   = prog_len;
                        pc_d    = '0;
                        state_d = S_FETCH;
                    end else begin
                        zero_done_d = 1'b1;
                    end
                end
            end

            S_FETCH: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                op_d    = rom_data[IW-1 -: OP_W];
                a_d     = rom_data[A_LSB +: RW];
                b_d     = rom_data[B_LSB +: RW];
                w_d     = rom_data[W_LSB +: RW];
                state_d = S_ISSUE;
            end

            S_ISSUE: begin
                // A store's stall has priority over the end-of-program
                // check; the check is repeated when the stall expires.
                if (iss.issue_ready) begin
                    pc_d = pc_inc;
                    if ((SW_STALL > 0) && (op_q == OP_SW)) begin
                        cnt_d   = STALL_INIT;
                        state_d = S_STALL;
                    end else if (pc_inc == len_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end

            S_STALL: begin
                // The counter hits zero on the edge that leaves this
                // state, giving exactly SW_STALL idle cycles. pc already
                // points past the store here.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CW'(1)) begin
                    state_d = (pc_q == len_q) ? S_DONE : S_FETCH;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode straight from the state so they line up with the
    // cycle each state occupies.
    assign rom_en          = (state_q == S_FETCH);
    assign rom_addr        = pc_q[AW-1:0];
    assign busy            = (state_q == S_FETCH) || (state_q == S_WAIT) ||
                             (state_q == S_ISSUE) || (state_q == S_STALL);
    assign done            = (state_q == S_DONE) || zero_done_q;

    assign iss.opcode      = op_q;
    assign iss.dir_a       = a_q;
    assign iss.dir_b       = b_q;
    assign iss.dir_w       = w_q;
    assign iss.issue_valid = (state_q == S_ISSUE);

    // Low word bits below the register fields carry no meaning here.
    generate
        if (W_LSB > 0) begin : g_low_bits
            logic unused_low_bits;
            assign unused_low_bits = ^rom_data[W_LSB-1:0];
        end
    endgenerate

endmodule

// File: tb/tb_secuenciador_instr.sv
// Self-checking bench for secuenciador_instr: drives programs held in a ROM
// model and compares fetches, issued fields, acceptance cycles and done/busy
// timing against a timeline model derived from the sequencer's rules.
module tb_secuenciador_instr;
    import secuenciador_instr_pkg::*;

    localparam int AW       = 5;
    localparam int IW       = 16;
    localparam int RW       = 4;
    localparam int SW_STALL = 2;
    localparam int MAXC     = 4096;
    localparam int BUDGET   = 3000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW:0]   prog_len;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [IW-1:0] rom_data;
    logic          busy;
    logic          done;

    secuenciador_instr_if #(.RW(RW)) iss_bus ();

    secuenciador_instr #(
        .AW(AW), .IW(IW), .RW(RW), .SW_STALL(SW_STALL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .prog_len (prog_len),
        .rom_en   (rom_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .busy     (busy),
        .done     (done),
        .iss      (iss_bus)
    );

    always #5 clk = ~clk;

    // Synchronous-read ROM model
    logic [IW-1:0] rom_mem [2**AW];
    always @(posedge clk) if (rom_en) rom_data <= rom_mem[rom_addr];

    int checks = 0;
    int errors = 0;

    // Observations from one run
    int          fetch_addr[$];
    int          fetch_cyc[$];
    int          acc_cyc[$];
    logic [13:0] iss_word[$];
    int          done_cnt, done_cyc, busy_cnt, hold_viol;
    bit          timed_out;

    // Stimulus controls
    bit ready_arr [MAXC];
    int extra_start_c = -1;
    int extra_len = 0;

    // Reference model results
    int exp_fetch[$];
    int exp_acc[$];
    int exp_done;

    task automatic fill_ready(input int pct);
        for (int c = 0; c < MAXC; c++) ready_arr[c] = ($urandom_range(0, 99) < pct);
    endtask

    // Cycle 1 is the cycle after the edge that samples start.
    task automatic run_program(input int len);
        logic [13:0] cur;
        logic [13:0] held;
        bit holding;
        int post;
        fetch_addr.delete(); fetch_cyc.delete(); acc_cyc.delete(); iss_word.delete();
        done_cnt = 0; done_cyc = -1; busy_cnt = 0; hold_viol = 0; timed_out = 0;
        holding = 0; post = -1; held = '0;
        @(negedge clk);
        start = 1'b1;
        prog_len = len[AW:0];
        iss_bus.issue_ready = 1'b0;
        for (int c = 1; c < BUDGET; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == extra_start_c) begin
                start = 1'b1;
                prog_len = extra_len[AW:0];
            end
            if (c == extra_start_c + 1) start = 1'b0;
            if (rom_en) begin
                fetch_addr.push_back(int'(rom_addr));
                fetch_cyc.push_back(c);
            end
            iss_bus.issue_ready = ready_arr[c];
            if (iss_bus.issue_valid) begin
                cur = {iss_bus.opcode, iss_bus.dir_a, iss_bus.dir_b, iss_bus.dir_w};
                if (holding && cur != held) hold_viol++;
                if (ready_arr[c]) begin
                    iss_word.push_back(cur);
                    acc_cyc.push_back(c);
                    holding = 0;
                end else begin
                    holding = 1;
                    held = cur;
                end
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
                if (post < 0) post = c + 2;
            end
            if (c == post) break;
        end
        if (post < 0) timed_out = 1;
        start = 1'b0;
        iss_bus.issue_ready = 1'b0;
    endtask

    // Timeline model: instruction i is fetched two cycles before it becomes
    // valid, is accepted on the first ready cycle at or after that, and the
    // next one becomes valid three cycles later plus the store stall.
    task automatic build_model(input int n);
        int vs, c, extra;
        exp_fetch.delete();
        exp_acc.delete();
        if (n == 0) begin
            exp_done = 1;
            return;
        end
        vs = 3;
        for (int i = 0; i < n; i++) begin
            exp_fetch.push_back(vs - 2);
            c = vs;
            while (c < MAXC - 1 && !ready_arr[c]) c++;
            exp_acc.push_back(c);
            extra = ((int'(rom_mem[i]) >> 14) == 3) ? SW_STALL : 0;
            if (i == n - 1) exp_done = c + 1 + extra;
            else vs = c + 3 + extra;
        end
    endtask

    task automatic test_reset();
        logic [AW+4*RW+6:0] outs;
        outs = {rom_en, rom_addr, iss_bus.opcode, iss_bus.dir_a, iss_bus.dir_b,
                iss_bus.dir_w, iss_bus.issue_valid, busy, done};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("[TB] FAIL reset_during: got %h expected 0", outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        outs = {rom_en, rom_addr, iss_bus.opcode, iss_bus.dir_a, iss_bus.dir_b,
                iss_bus.dir_w, iss_bus.issue_valid, busy, done};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("[TB] FAIL reset_after: got %h expected 0", outs);
        end
    endtask

    task automatic test_single();
        rom_mem[0] = 16'b00_0001_0010_0011_00;
        fill_ready(100);
        run_program(1);
        checks++;
        if (fetch_cyc.size() != 1 || fetch_cyc[0] != 1 || fetch_addr[0] != 0) begin
            errors++;
            $display("[TB] FAIL single_fetch: got %0d fetches first cycle %0d expected 1 fetch at cycle 1 addr 0",
                     fetch_cyc.size(), fetch_cyc.size() > 0 ? fetch_cyc[0] : -1);
        end
        checks++;
        if (acc_cyc.size() != 1 || acc_cyc[0] != 3) begin
            errors++;
            $display("[TB] FAIL single_issue_cycle: got %0d expected 3",
                     acc_cyc.size() > 0 ? acc_cyc[0] : -1);
        end
        checks++;
        if (iss_word.size() != 1 || iss_word[0] !== 14'b00_0001_0010_0011) begin
            errors++;
            $display("[TB] FAIL single_fields: got %b expected 00000100100011",
                     iss_word.size() > 0 ? iss_word[0] : 14'h0);
        end
        checks++;
        if (done_cyc != 4 || done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL single_done: got cycle %0d count %0d expected cycle 4 count 1", done_cyc, done_cnt);
        end
        checks++;
        if (busy_cnt != 3) begin
            errors++;
            $display("[TB] FAIL single_busy: got %0d expected 3", busy_cnt);
        end
    endtask

    task automatic test_backpressure();
        rom_mem[0] = 16'h1234;
        rom_mem[1] = 16'h559C;
        rom_mem[2] = 16'h0ABC;
        fill_ready(100);
        for (int c = 6; c <= 10; c++) ready_arr[c] = 1'b0;
        run_program(3);
        checks++;
        if (acc_cyc.size() != 3 || acc_cyc[1] != 11) begin
            errors++;
            $display("[TB] FAIL bp_accept: got %0d expected 11", acc_cyc.size() > 1 ? acc_cyc[1] : -1);
        end
        checks++;
        if (hold_viol != 0) begin
            errors++;
            $display("[TB] FAIL bp_hold: got %0d changes expected 0", hold_viol);
        end
        checks++;
        if (iss_word.size() < 2 || iss_word[1] !== 14'(16'h559C >> 2)) begin
            errors++;
            $display("[TB] FAIL bp_fields: got %h expected %h",
                     iss_word.size() > 1 ? iss_word[1] : 14'h0, 14'(16'h559C >> 2));
        end
        checks++;
        if (fetch_cyc.size() != 3 || fetch_cyc[2] != 12 || fetch_addr[2] != 2) begin
            errors++;
            $display("[TB] FAIL bp_third_fetch: got %0d fetches last cycle %0d expected cycle 12 addr 2",
                     fetch_cyc.size(), fetch_cyc.size() > 2 ? fetch_cyc[2] : -1);
        end
        checks++;
        if (done_cyc != 15) begin
            errors++;
            $display("[TB] FAIL bp_done: got %0d expected 15", done_cyc);
        end
    endtask

    task automatic test_store_stall();
        rom_mem[0] = 16'h8A5C;
        rom_mem[1] = 16'hC3F0;
        rom_mem[2] = 16'h1111;
        fill_ready(100);
        run_program(3);
        checks++;
        if (fetch_cyc.size() != 3 || fetch_cyc[1] != 4 || fetch_cyc[2] != 9) begin
            errors++;
            $display("[TB] FAIL stall_fetch: got %0d fetches last cycle %0d expected ROM[2] at cycle 9",
                     fetch_cyc.size(), fetch_cyc.size() > 2 ? fetch_cyc[2] : -1);
        end
        checks++;
        if (done_cyc != 12) begin
            errors++;
            $display("[TB] FAIL stall_done: got %0d expected 12", done_cyc);
        end
        checks++;
        if (busy_cnt != 11) begin
            errors++;
            $display("[TB] FAIL stall_busy: got %0d expected 11", busy_cnt);
        end
    endtask

    task automatic test_zero_len();
        fill_ready(100);
        run_program(0);
        checks++;
        if (done_cyc != 1 || done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL zero_done: got cycle %0d count %0d expected cycle 1 count 1", done_cyc, done_cnt);
        end
        checks++;
        if (fetch_addr.size() != 0 || busy_cnt != 0) begin
            errors++;
            $display("[TB] FAIL zero_idle: got %0d fetches %0d busy expected 0 and 0", fetch_addr.size(), busy_cnt);
        end
    endtask

    task automatic test_random_programs();
        int n;
        for (int p = 0; p < 6; p++) begin
            n = (p == 0) ? 32 : int'($urandom_range(1, 32));
            for (int i = 0; i < 2**AW; i++) rom_mem[i] = 16'($urandom);
            fill_ready(p == 0 ? 100 : 70);
            run_program(n);
            build_model(n);
            checks++;
            if (timed_out || fetch_addr.size() != n || acc_cyc.size() != n) begin
                errors++;
                $display("[TB] FAIL rand_counts p%0d: got %0d fetches %0d issues timeout %0d expected %0d",
                         p, fetch_addr.size(), acc_cyc.size(), timed_out, n);
            end
            for (int i = 0; i < n && i < fetch_addr.size(); i++) begin
                checks++;
                if (fetch_addr[i] != i || fetch_cyc[i] != exp_fetch[i]) begin
                    errors++;
                    $display("[TB] FAIL rand_fetch p%0d i%0d: got addr %0d cycle %0d expected addr %0d cycle %0d",
                             p, i, fetch_addr[i], fetch_cyc[i], i, exp_fetch[i]);
                end
            end
            for (int i = 0; i < n && i < acc_cyc.size(); i++) begin
                checks++;
                if (acc_cyc[i] != exp_acc[i] || iss_word[i] !== 14'(rom_mem[i] >> 2)) begin
                    errors++;
                    $display("[TB] FAIL rand_issue p%0d i%0d: got cycle %0d word %h expected cycle %0d word %h",
                             p, i, acc_cyc[i], iss_word[i], exp_acc[i], 14'(rom_mem[i] >> 2));
                end
            end
            checks++;
            if (done_cyc != exp_done || done_cnt != 1 || busy_cnt != exp_done - 1 || hold_viol != 0) begin
                errors++;
                $display("[TB] FAIL rand_done p%0d: got done %0d x%0d busy %0d holdviol %0d expected done %0d x1 busy %0d",
                         p, done_cyc, done_cnt, busy_cnt, hold_viol, exp_done, exp_done - 1);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int bad;
        for (int i = 0; i < 2**AW; i++) rom_mem[i] = 16'($urandom);
        fill_ready(80);
        extra_start_c = 5;
        extra_len = 2;
        run_program(6);
        extra_start_c = -1;
        build_model(6);
        bad = 0;
        for (int i = 0; i < 6 && i < iss_word.size(); i++)
            if (iss_word[i] !== 14'(rom_mem[i] >> 2) || acc_cyc[i] != exp_acc[i]) bad++;
        checks++;
        if (iss_word.size() != 6 || bad != 0) begin
            errors++;
            $display("[TB] FAIL busy_start_issue: got %0d issues %0d wrong expected 6 issues 0 wrong", iss_word.size(), bad);
        end
        checks++;
        if (done_cyc != exp_done || done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL busy_start_done: got %0d x%0d expected %0d x1", done_cyc, done_cnt, exp_done);
        end
    endtask

    task automatic test_reset_mid();
        int waited, dn;
        logic [AW+4*RW+6:0] outs;
        for (int i = 0; i < 4; i++) rom_mem[i] = 16'(($urandom_range(0, 2) << 14) | ($urandom & 16'h3FFF));
        fill_ready(0);
        @(negedge clk);
        start = 1'b1;
        prog_len = 4;
        iss_bus.issue_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (!iss_bus.issue_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (iss_bus.issue_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reach_issue: got %b expected 1", iss_bus.issue_valid);
        end
        rst_n = 1'b0;
        #1;
        outs = {rom_en, rom_addr, iss_bus.opcode, iss_bus.dir_a, iss_bus.dir_b,
                iss_bus.dir_w, iss_bus.issue_valid, busy, done};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("[TB] FAIL mid_reset_outs: got %h expected 0", outs);
        end
        dn = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) dn++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (done) dn++;
        end
        checks++;
        if (dn != 0) begin
            errors++;
            $display("[TB] FAIL mid_no_done: got %0d pulses expected 0", dn);
        end
        fill_ready(100);
        run_program(4);
        build_model(4);
        checks++;
        if (fetch_addr.size() != 4 || fetch_addr[0] != 0 || fetch_cyc[0] != 1) begin
            errors++;
            $display("[TB] FAIL mid_restart_fetch: got %0d fetches first addr %0d expected 4 from addr 0",
                     fetch_addr.size(), fetch_addr.size() > 0 ? fetch_addr[0] : -1);
        end
        checks++;
        if (done_cyc != exp_done) begin
            errors++;
            $display("[TB] FAIL mid_restart_done: got %0d expected %0d", done_cyc, exp_done);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        prog_len = '0;
        iss_bus.issue_ready = 1'b0;
        for (int i = 0; i < 2**AW; i++) rom_mem[i] = '0;
        repeat (2) @(negedge clk);
        $display("[TB] starting secuenciador_instr bench");
        test_reset();
        test_single();
        test_backpressure();
        test_store_stall();
        test_zero_len();
        test_random_programs();
        test_start_while_busy();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/secuenciador_instr.md
Name: secuenciador_instr

Overview:
- Instruction fetch/issue sequencer. It is the producing end of the opcode interface consumed by the control decoder.
- Walks a program held in a synchronous-read instruction ROM and splits each word into opcode and register-file addresses.
- Presents each instruction to the decode/datapath stage with a valid/ready handshake.
- Inserts a fixed stall after every store (opcode 11) so the data memory write completes before the next fetch.

Parameters:
- AW, 5: instruction ROM address width; program holds up to 2^AW words.
- IW, 16: instruction word width.
- RW, 4: register-file address width.
- SW_STALL, 2: extra idle cycles after a store is accepted; 0 means no stall.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins execution at address 0.
- prog_len  input  AW+1  number of instructions; sampled when start is accepted.
- rom_en  output  1  ROM read enable.
- rom_addr  output  AW  ROM read address.
- rom_data  input  IW  ROM read data; valid the cycle after rom_en.
- opcode  output  2  issued opcode; this is what the control decoder receives.
- dir_a  output  RW  source A register address.
- dir_b  output  RW  source B register address.
- dir_w  output  RW  destination register address.
- issue_valid  output  1  the issued fields are valid.
- issue_ready  input  1  the consumer accepts the instruction.
- busy  output  1  high from start acceptance until the done pulse.
- done  output  1  one-cycle pulse when the program completes.

Behaviour:
- Instruction word layout:
  - [IW-1:IW-2] opcode
  - next RW bits: dir_a
  - next RW bits: dir_b
  - next RW bits: dir_w
  - remaining low bits ignored
- Reset: state IDLE; pc=0, rom_en=0, rom_addr=0, opcode=0, dir_a/b/w=0, issue_valid=0, busy=0, done=0, stall counter=0. Reset asserted mid-program aborts immediately with no done pulse.
- IDLE:
  - start=1 with prog_len!=0: latch prog_len, pc=0, busy=1, go to FETCH.
  - start=1 with prog_len=0: done pulses 1 the next cycle, busy stays 0, state stays IDLE.
- FETCH (1 cycle): rom_en=1, rom_addr=pc; go to WAIT.
- WAIT (1 cycle): rom_en=0; capture rom_data fields into the issue registers; issue_valid=1 from the next cycle; go to ISSUE.
- ISSUE:
  - While issue_valid=1 and issue_ready=0, opcode and dir_* are held stable.
  - On issue_valid&issue_ready at a clock edge: issue_valid=0 the next cycle and pc=pc+1.
  - Then, in priority order: if opcode==11 and SW_STALL>0, load counter=SW_STALL and go to STALL. Else if pc+1==prog_len, go to DONE. Else go to FETCH.
- STALL: counter decrements each cycle. When it reaches 0, apply the same DONE/FETCH decision.
- DONE (1 cycle): done=1, busy=0; go to IDLE.
- start is ignored whenever busy=1.
- Timing:
  - Latency: start sampled at edge 0 → rom_en high in cycle 1 → issue_valid high from cycle 3.
  - Throughput with issue_ready tied 1: one instruction per 3 cycles (FETCH, WAIT, ISSUE).
  - Each accepted store adds SW_STALL cycles.
- pc/prog_len comparison is done in AW+1 bits, so prog_len=2^AW runs the full ROM. pc never wraps; a program ends at prog_len.
- issue_ready while issue_valid=0 has no effect.
- opcode/dir_* keep the last issued value outside ISSUE and are not cleared.

Decomposition:
- Shared package holds:
  - opcode constants OP_SUMA=2'b00, OP_RESTA=2'b01, OP_TERN=2'b10, OP_SW=2'b11
  - state encoding IDLE/FETCH/WAIT/ISSUE/STALL/DONE
  - instruction field offset constants
- The control decoder uses the same opcode constants.
- No sub-module is needed; the stall counter lives inline.

Test Plan:
- Reset mid-program: assert rst_n=0 while in ISSUE → all outputs at reset values, no done pulse. After release, start runs again from pc=0.
- Single instruction: ROM[0]=16'b00_0001_0010_0011_00, prog_len=1, issue_ready=1, start pulse → rom_en/rom_addr=0 in cycle 1; opcode=00, dir_a=1, dir_b=2, dir_w=3 with issue_valid in cycle 3; done pulse in cycle 4; busy back to 0.
- Backpressure: issue_ready=0 for 5 cycles on the second instruction (opcode 01) → issue_valid and fields held constant; pc advances only after the acceptance edge.
- Store stall: program {10, 11, 00}, SW_STALL=2, issue_ready=1 → 2-cycle gap between store acceptance and the FETCH of ROM[2]; total 11 cycles from start to done.
- Edge lengths:
  - prog_len=0 → done pulse one cycle after start, no rom_en.
  - prog_len=32 (AW=5) → all 32 addresses fetched in order, then done.
- start while busy → ignored; the sequence is unaffected.
